// File: rtl/circle_pkg.sv
// rtl/circle_pkg.sv - shared types and constants for the circle job scheduler
// Contents: screen dimensions, coordinate field widths derived from them,
//           scheduler FSM state enum and the packed circle command record.
package circle_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Coordinate fields are just wide enough to address the screen.
    localparam int X_W = $clog2(SCREEN_W);
    localparam int Y_W = $clog2(SCREEN_H);
    localparam int R_W = 8;
    localparam int C_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [X_W-1:0] centre_x;
        logic [Y_W-1:0] centre_y;
        logic [R_W-1:0] radius;
        logic [C_W-1:0] colour;
    } circle_cmd_t;

    localparam int CMD_W = $bits(circle_cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with flush
// Ports: clk, rst (async, active high), flush (sync clear, wins over push/pop),
//        push/wr_data, pop/rd_data (head, combinational), full, empty,
//        level (occupancy 0..DEPTH).
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Flush discards anything offered in the same cycle.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/circle_scheduler.sv
// rtl/circle_scheduler.sv - queues circle commands and hands them one at a time to the engine
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready + cmd_* payload in;
//        abort (sync flush of queue and job); eng_* job out, eng_start (held until
//        eng_done), eng_done in; busy, level (queue occupancy).
// Option: CIRCLE_SCHED_STATS_EN adds jobs_done, a saturating count of completed jobs.
module circle_scheduler
    import circle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_centre_x,
    input  logic [6:0]             cmd_centre_y,
    input  logic [7:0]             cmd_radius,
    input  logic [2:0]             cmd_colour,
    input  logic                   abort,
    output logic [7:0]             eng_centre_x,
    output logic [6:0]             eng_centre_y,
    output logic [7:0]             eng_radius,
    output logic [2:0]             eng_colour,
    output logic                   eng_start,
    input  logic                   eng_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef CIRCLE_SCHED_STATS_EN
    ,
    output logic [15:0]            jobs_done
`endif
);

    sched_state_t state;
    sched_state_t next_state;
    circle_cmd_t  fifo_wr;
    circle_cmd_t  fifo_rd;
    circle_cmd_t  job_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         start_d;

    assign fifo_wr   = {cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .push    (push),
        .wr_data (fifo_wr),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty) next_state = LOAD;
            LOAD: begin
                pop        = 1'b1;
                next_state = RUN;
            end
            RUN:     if (eng_done) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            pop        = 1'b0;
            next_state = (state == IDLE) ? IDLE : RELEASE;
        end
        // eng_start is the registered image of "next state is RUN".
        start_d = (next_state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            eng_start <= 1'b0;
            job_q     <= '0;
        end else begin
            state     <= next_state;
            eng_start <= start_d;
            if (pop) job_q <= fifo_rd;
        end
    end

    assign eng_centre_x = job_q.centre_x;
    assign eng_centre_y = job_q.centre_y;
    assign eng_radius   = job_q.radius;
    assign eng_colour   = job_q.colour;
    assign busy         = (state != IDLE) || !fifo_empty;

`ifdef CIRCLE_SCHED_STATS_EN
    // Counts completions signalled by the engine; an aborted job is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_done <= '0;
        end else if (state == RUN && eng_done && !abort && jobs_done != 16'hFFFF) begin
            jobs_done <= jobs_done + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_circle_scheduler.sv
// tb/tb_circle_scheduler.sv - self-checking bench for circle_scheduler
module tb_circle_scheduler;
    import circle_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_centre_x = '0;
    logic [6:0] cmd_centre_y = '0;
    logic [7:0] cmd_radius = '0;
    logic [2:0] cmd_colour = '0;
    logic       abort = 1'b0;
    logic [7:0] eng_centre_x;
    logic [6:0] eng_centre_y;
    logic [7:0] eng_radius;
    logic [2:0] eng_colour;
    logic       eng_start;
    logic       eng_done = 1'b0;
    logic       busy;
    logic [$clog2(DEPTH):0] level;
`ifdef CIRCLE_SCHED_STATS_EN
    logic [15:0] jobs_done;
`endif

    always #5 clk = ~clk;

    circle_scheduler #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_centre_x (cmd_centre_x),
        .cmd_centre_y (cmd_centre_y),
        .cmd_radius   (cmd_radius),
        .cmd_colour   (cmd_colour),
        .abort        (abort),
        .eng_centre_x (eng_centre_x),
        .eng_centre_y (eng_centre_y),
        .eng_radius   (eng_radius),
        .eng_colour   (eng_colour),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .busy         (busy),
        .level        (level)
`ifdef CIRCLE_SCHED_STATS_EN
        ,
        .jobs_done    (jobs_done)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          v;
        logic [25:0] cmd;
        bit          done;
        bit          ab;
        bit          e_start;
        int          e_level;
        bit          e_ready;
        bit          e_busy;
        bit          chk_job;
        logic [25:0] e_job;
    } vec_t;

    vec_t        tbl[$];
    logic [25:0] bc [1:6];
    logic [25:0] cmd_a;

    // Reference model: pending queue plus the job phase expressed as
    // "engine running", "load pending" and "release cycles remaining".
    logic [25:0] mq[$];
    bit          m_start;
    bit          m_load;
    int          m_wait;
    logic [25:0] m_job;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] mkcmd(input int x, input int y, input int r, input int c);
        return {x[7:0], y[6:0], r[7:0], c[2:0]};
    endfunction

    function automatic vec_t mk(input bit v, input logic [25:0] c, input bit d, input bit a,
                                input bit s, input int l, input bit r, input bit b,
                                input bit cj, input logic [25:0] j);
        vec_t t;
        t.v = v; t.cmd = c; t.done = d; t.ab = a;
        t.e_start = s; t.e_level = l; t.e_ready = r; t.e_busy = b;
        t.chk_job = cj; t.e_job = j;
        return t;
    endfunction

    function automatic logic [25:0] job_bus();
        return {eng_centre_x, eng_centre_y, eng_radius, eng_colour};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit v, input logic [25:0] c);
        cmd_valid = v;
        {cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour} = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_cmd(1'b0, '0);
        eng_done = 1'b0;
        abort = 1'b0;
        tick();
        rst = 1'b0;
        mq.delete();
        m_start = 1'b0;
        m_load = 1'b0;
        m_wait = 0;
        m_job = '0;
    endtask

    function automatic bit m_idle();
        return !m_start && !m_load && (m_wait == 0);
    endfunction

    task automatic model_step(input bit v, input logic [25:0] d, input bit dn, input bit ab);
        int sz;
        bit rdy;
        sz  = mq.size();
        rdy = (sz < DEPTH);
        if (ab) begin
            mq.delete();
            if (!m_idle()) begin
                m_start = 1'b0;
                m_load = 1'b0;
                m_wait = 1;
            end
            return;
        end
        if (m_start) begin
            if (dn) begin
                m_start = 1'b0;
                m_wait = 1;
            end
        end else if (m_load) begin
            m_job = mq.pop_front();
            m_load = 1'b0;
            m_start = 1'b1;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (sz > 0) begin
            m_load = 1'b1;
        end
        if (v && rdy) mq.push_back(d);
    endtask

    initial begin
        int pulses;
        int low;
        int hi;
        int minlow;
        bit prev;
        int starts;
        logic [25:0] x;

        cmd_a = mkcmd(80, 60, 30, 2);
        for (int k = 1; k <= 6; k++) bc[k] = mkcmd(10 + k * 20, 5 + k * 10, k + 3, k);

        // Reset state, both while asserted before any edge and after an edge.
        #3;
        chk("rst start", eng_start, 0);
        chk("rst level", level, 0);
        chk("rst ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst job", job_bus(), 0);
        tick();
        chk("rst hold start", eng_start, 0);
        chk("rst hold level", level, 0);
        rst = 1'b0;

        // Single job, then fill to DEPTH with one refused push, then drain in order.
        tbl.push_back(mk(1, cmd_a, 0, 0, 0, 1, 1, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0, 1, 1, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 1, 0, 1, 1, 1, cmd_a));
        for (int k = 0; k < 12; k++) tbl.push_back(mk(0, '0, 0, 0, 1, 0, 1, 1, 1, cmd_a));
        tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(1, bc[1], 0, 0, 0, 1, 1, 1, 0, '0));
        tbl.push_back(mk(1, bc[2], 0, 0, 0, 2, 1, 1, 0, '0));
        tbl.push_back(mk(1, bc[3], 0, 0, 1, 2, 1, 1, 1, bc[1]));
        tbl.push_back(mk(1, bc[4], 0, 0, 1, 3, 1, 1, 1, bc[1]));
        tbl.push_back(mk(1, bc[5], 0, 0, 1, 4, 0, 1, 1, bc[1]));
        tbl.push_back(mk(1, bc[6], 0, 0, 1, 4, 0, 1, 1, bc[1]));
        for (int k = 2; k <= 5; k++) begin
            int l;
            l = 6 - k;
            tbl.push_back(mk(0, '0, 1, 0, 0, l, l < DEPTH, 1, 0, '0));
            tbl.push_back(mk(0, '0, 0, 0, 0, l, l < DEPTH, 1, 0, '0));
            tbl.push_back(mk(0, '0, 0, 0, 0, l, l < DEPTH, 1, 0, '0));
            tbl.push_back(mk(0, '0, 0, 0, 1, l - 1, 1, 1, 1, bc[k]));
        end
        tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0, 0, 1, 0, 0, '0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_cmd(tbl[i].v, tbl[i].cmd);
            eng_done = tbl[i].done;
            abort = tbl[i].ab;
            tick();
            chk($sformatf("tbl%0d start", i), eng_start, tbl[i].e_start);
            chk($sformatf("tbl%0d level", i), level, tbl[i].e_level);
            chk($sformatf("tbl%0d ready", i), cmd_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].chk_job) chk($sformatf("tbl%0d job", i), job_bus(), tbl[i].e_job);
        end
        set_cmd(1'b0, '0);
        eng_done = 1'b0;

        // Back-to-back: three jobs, engine answers 10 cycles after each start.
        pulses = 0; low = 100; hi = 0; minlow = 1000; prev = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            set_cmd(cyc < 3, (cyc < 3) ? bc[cyc + 1] : '0);
            eng_done = (hi == 10);
            tick();
            if (eng_start && !prev) begin
                pulses++;
                if (pulses > 1 && low < minlow) minlow = low;
                if (pulses <= 3) chk($sformatf("b2b job%0d", pulses), job_bus(), bc[pulses]);
            end
            if (eng_start) begin hi++; low = 0; end
            else begin hi = 0; low++; end
            prev = eng_start;
        end
        eng_done = 1'b0;
        chk("b2b pulses", pulses, 3);
        chk("b2b gap", minlow, 3);
        chk("b2b busy", busy, 0);

        // Abort during RUN with two queued; same-cycle push must be dropped.
        for (int k = 1; k <= 3; k++) begin
            set_cmd(1'b1, bc[k]);
            tick();
        end
        set_cmd(1'b0, '0);
        chk("abort pre start", eng_start, 1);
        chk("abort pre level", level, 2);
        abort = 1'b1;
        set_cmd(1'b1, bc[4]);
        tick();
        abort = 1'b0;
        set_cmd(1'b0, '0);
        chk("abort start", eng_start, 0);
        chk("abort level", level, 0);
        chk("abort release busy", busy, 1);
        tick();
        chk("abort idle busy", busy, 0);
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (eng_start) starts++;
        end
        chk("abort no starts", starts, 0);

        // Asynchronous reset between edges during RUN with a queued backlog.
        set_cmd(1'b1, bc[1]); tick();
        set_cmd(1'b1, bc[2]); tick();
        set_cmd(1'b1, bc[3]); tick();
        set_cmd(1'b0, '0);
        chk("arst run", eng_start, 1);
        chk("arst pre level", level, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst start", eng_start, 0);
        chk("arst level", level, 0);
        chk("arst busy", busy, 0);
        #2 rst = 1'b0;
        x = bc[5];
        set_cmd(1'b1, x);
        tick();
        set_cmd(1'b0, '0);
        chk("arst lat k", eng_start, 0);
        tick();
        chk("arst lat k+1", eng_start, 0);
        tick();
        chk("arst lat k+2", eng_start, 1);
        chk("arst job", job_bus(), x);
        eng_done = 1'b1; tick();
        eng_done = 1'b0; tick();

`ifdef CIRCLE_SCHED_STATS_EN
        do_reset();
        for (int j = 0; j < 4; j++) begin
            set_cmd(1'b1, bc[j + 1]); tick();
            set_cmd(1'b0, '0); tick(); tick();
            chk("stats run", eng_start, 1);
            eng_done = 1'b1; tick();
            eng_done = 1'b0; tick();
        end
        chk("stats count", jobs_done, 4);
        abort = 1'b1; tick();
        abort = 1'b0;
        chk("stats after abort", jobs_done, 4);
        rst = 1'b1;
        #1;
        chk("stats after rst", jobs_done, 0);
        #2 rst = 1'b0;
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            bit v;
            bit dn;
            bit ab;
            logic [25:0] d;
            v  = ($urandom_range(99, 0) < 55);
            dn = ($urandom_range(9, 0) == 0);
            ab = ($urandom_range(99, 0) == 0);
            d  = mkcmd($urandom_range(SCREEN_W - 1, 0), $urandom_range(SCREEN_H - 1, 0),
                       $urandom_range(255, 0), $urandom_range(7, 0));
            set_cmd(v, d);
            eng_done = dn;
            abort = ab;
            model_step(v, d, dn, ab);
            tick();
            chk("rnd start", eng_start, m_start);
            chk("rnd level", level, mq.size());
            chk("rnd ready", cmd_ready, mq.size() < DEPTH);
            chk("rnd busy", busy, !m_idle() || mq.size() > 0);
            if (m_start) chk("rnd job", job_bus(), m_job);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
